// File: rtl/psg_pkg.sv
// psg_pkg
// Shared widths and the bus phase encoding for the PSG bus writer.
//   PSG_ADDR_W : width of a PSG register index
//   PSG_DATA_W : width of a PSG register value and of the ui_in bus
//   phase_e    : PH_DATA (bus sampled as data) / PH_ADDR (bus sampled as address)
package psg_pkg;

  localparam int PSG_ADDR_W = 4;
  localparam int PSG_DATA_W = 8;
  localparam int PSG_REQ_W  = PSG_ADDR_W + PSG_DATA_W;

  typedef enum logic {
    PH_DATA = 1'b0,
    PH_ADDR = 1'b1
  } phase_e;

  // Zero-extend a register index onto the data bus.
  function automatic logic [PSG_DATA_W-1:0] addr_to_bus(input logic [PSG_ADDR_W-1:0] addr);
    return {{(PSG_DATA_W-PSG_ADDR_W){1'b0}}, addr};
  endfunction

endpackage

// File: rtl/psg_req_fifo.sv
// psg_req_fifo
// Request buffer for the PSG bus writer. DEPTH must be 1 or a power of two
// (2..16). DEPTH=1 degenerates to a single holding register.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset (clears pointers/occupancy)
//   push, din   : write an entry (ignored when full)
//   pop, dout   : drop the head entry (ignored when empty); dout shows the head
//   full, empty : occupancy flags
module psg_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  generate
    if (DEPTH == 1) begin : g_hold
      logic             held_q;
      logic             held_d;
      logic [WIDTH-1:0] hold_q;

      always_comb begin
        held_d = held_q;
        if (pop && held_q) begin
          held_d = 1'b0;
        end else if (push && !held_q) begin
          held_d = 1'b1;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          held_q <= 1'b0;
        end else begin
          held_q <= held_d;
        end
      end

      // Storage needs no reset: it is only read while held_q is set.
      always_ff @(posedge clk) begin
        if (push && !held_q) begin
          hold_q <= din;
        end
      end

      assign dout  = hold_q;
      assign full  = held_q;
      assign empty = !held_q;
    end else begin : g_ring
      localparam int PTR_W = $clog2(DEPTH);

      logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
      logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
      logic [PTR_W:0]   count_q, count_d;
      logic [WIDTH-1:0] mem_q [DEPTH];
      logic             do_push;
      logic             do_pop;

      assign full    = (count_q == (PTR_W+1)'(DEPTH));
      assign empty   = (count_q == '0);
      assign do_push = push && !full;
      assign do_pop  = pop && !empty;
      assign dout    = mem_q[rd_ptr_q];

      // Pointers are exactly log2(DEPTH) bits, so the increment wraps for free.
      always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
          wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
          rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
          2'b10:   count_d = count_q + (PTR_W+1)'(1);
          2'b01:   count_d = count_q - (PTR_W+1)'(1);
          default: count_d = count_q;
        endcase
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          wr_ptr_q <= '0;
          rd_ptr_q <= '0;
          count_q  <= '0;
        end else begin
          wr_ptr_q <= wr_ptr_d;
          rd_ptr_q <= rd_ptr_d;
          count_q  <= count_d;
        end
      end

      always_ff @(posedge clk) begin
        if (do_push) begin
          mem_q[wr_ptr_q] <= din;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/psg_bus_writer.sv
// psg_bus_writer
// Serialises register-write requests onto the PSG's multiplexed ui_in bus.
// The PSG latch toggles every cycle; this block keeps a phase register in
// lockstep and loads bus_out one edge ahead of each sampling cycle.
// Configuration macro PSG_BUS_WRITER_FIFO_EN: when defined, requests are
// buffered in a FIFO_DEPTH-entry FIFO; otherwise a single holding register
// is used and FIFO_DEPTH has no effect. Bus timing is identical either way.
// Ports:
//   clk, rst_n          : clock shared with the PSG, async active-low reset
//   req_valid/req_ready : request handshake
//   req_addr, req_data  : PSG register index and value
//   bus_out             : registered PSG data bus
//   phase               : 0 = data phase, 1 = address phase
//   busy                : requests queued or a transaction in flight
//   wr_done             : one-cycle pulse after a transaction's data phase
//
// state   | meaning
// PH_DATA | PSG samples bus_out as data this cycle; next edge loads an address
// PH_ADDR | PSG samples bus_out as address this cycle; next edge loads data
module psg_bus_writer
  import psg_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [PSG_ADDR_W-1:0] req_addr,
  input  logic [PSG_DATA_W-1:0] req_data,
  output logic [PSG_DATA_W-1:0] bus_out,
  output logic                  phase,
  output logic                  busy,
  output logic                  wr_done
);

`ifdef PSG_BUS_WRITER_FIFO_EN
  localparam bit FIFO_EN = 1'b1;
`else
  localparam bit FIFO_EN = 1'b0;
`endif
  localparam int DEPTH_EFF = FIFO_EN ? FIFO_DEPTH : 1;

  phase_e                phase_q, phase_d;
  logic [PSG_DATA_W-1:0] bus_q, bus_d;
  logic [PSG_ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [PSG_DATA_W-1:0] cur_data_q, cur_data_d;
  logic                  xact_q, xact_d;
  logic                  wr_done_q, wr_done_d;

  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [PSG_REQ_W-1:0]  fifo_dout;
  logic [PSG_ADDR_W-1:0] head_addr;
  logic [PSG_DATA_W-1:0] head_data;

  assign req_ready = !fifo_full;
  assign fifo_push = req_valid && !fifo_full;
  assign head_addr = fifo_dout[PSG_REQ_W-1:PSG_DATA_W];
  assign head_data = fifo_dout[PSG_DATA_W-1:0];

  psg_req_fifo #(
    .DEPTH (DEPTH_EFF),
    .WIDTH (PSG_REQ_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   ({req_addr, req_data}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // xact_q spans the address and data cycles of a popped request; it is what
  // separates real writes from idle re-presentations of the last pair.
  always_comb begin
    phase_d    = (phase_q == PH_DATA) ? PH_ADDR : PH_DATA;
    bus_d      = bus_q;
    cur_addr_d = cur_addr_q;
    cur_data_d = cur_data_q;
    xact_d     = xact_q;
    wr_done_d  = 1'b0;
    fifo_pop   = 1'b0;
    case (phase_q)
      PH_DATA: begin
        fifo_pop  = !fifo_empty;
        wr_done_d = xact_q;
        xact_d    = !fifo_empty;
        if (!fifo_empty) begin
          cur_addr_d = head_addr;
          cur_data_d = head_data;
          bus_d      = addr_to_bus(head_addr);
        end else begin
          bus_d = addr_to_bus(cur_addr_q);
        end
      end
      PH_ADDR: begin
        bus_d = cur_data_q;
      end
      default: begin
        bus_d = bus_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q    <= PH_DATA;
      bus_q      <= '0;
      cur_addr_q <= '0;
      cur_data_q <= '0;
      xact_q     <= 1'b0;
      wr_done_q  <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      bus_q      <= bus_d;
      cur_addr_q <= cur_addr_d;
      cur_data_q <= cur_data_d;
      xact_q     <= xact_d;
      wr_done_q  <= wr_done_d;
    end
  end

  assign bus_out = bus_q;
  assign phase   = phase_q;
  assign busy    = !fifo_empty || xact_q;
  assign wr_done = wr_done_q;

endmodule

// File: tb/tb_psg_bus_writer.sv
module tb_psg_bus_writer;

`ifdef PSG_BUS_WRITER_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [3:0] req_addr = 4'h0;
  logic [7:0] req_data = 8'h00;
  logic [7:0] bus_out;
  logic       phase;
  logic       busy;
  logic       wr_done;

  psg_bus_writer #(.FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .bus_out   (bus_out),
    .phase     (phase),
    .busy      (busy),
    .wr_done   (wr_done)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Reference model: each accepted request gets an issue cycle (its address
  // cycle) from the latency/throughput rules; outputs follow from that timeline.
  int         q_acc[$];
  int         q_iss[$];
  logic [3:0] q_addr[$];
  logic [7:0] q_data[$];
  logic [7:0] psg_regs[16];
  logic [3:0] psg_latch;
  logic [7:0] sb[16];

  function automatic void model_clear();
    q_acc.delete(); q_iss.delete(); q_addr.delete(); q_data.delete();
    for (int i = 0; i < 16; i++) begin
      psg_regs[i] = 8'h00;
      sb[i] = 8'h00;
    end
    psg_latch = 4'h0;
  endfunction

  function automatic void model_push(int e, logic [3:0] a, logic [7:0] d);
    int iss;
    iss = (e % 2 == 1) ? e + 2 : e + 1;
    if (q_iss.size() > 0 && iss < q_iss[$] + 2) iss = q_iss[$] + 2;
    q_acc.push_back(e); q_iss.push_back(iss);
    q_addr.push_back(a); q_data.push_back(d);
    sb[a] = d;
  endfunction

  function automatic logic [7:0] exp_bus(int n);
    int t;
    int idx;
    t = (n % 2 == 1) ? n : n - 1;
    idx = -1;
    foreach (q_iss[i]) if (q_iss[i] <= t) idx = i;
    if (idx < 0) return 8'h00;
    return (n % 2 == 1) ? {4'h0, q_addr[idx]} : q_data[idx];
  endfunction

  function automatic int occ(int n);
    int c;
    c = 0;
    foreach (q_iss[i]) if (q_acc[i] <= n && q_iss[i] > n) c++;
    return c;
  endfunction

  function automatic logic exp_busy(int n);
    if (occ(n) > 0) return 1'b1;
    foreach (q_iss[i]) if (q_iss[i] <= n && n <= q_iss[i] + 1) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic exp_wr_done(int n);
    foreach (q_iss[i]) if (q_iss[i] == n - 2) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic exp_ready(int n);
    return (occ(n) < CAP) ? 1'b1 : 1'b0;
  endfunction

  // One clock: handshake, edge, then the PSG model samples the bus mid-cycle.
  task automatic tick(output bit acc);
    logic [3:0] a;
    logic [7:0] d;
    acc = req_valid && req_ready;
    a = req_addr;
    d = req_data;
    @(posedge clk);
    cyc++;
    if (acc) model_push(cyc, a, d);
    @(negedge clk);
    if (cyc % 2 == 1) psg_latch = bus_out[3:0];
    else psg_regs[psg_latch] = bus_out;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_clear();
    rst_n = 1'b1;
    cyc = 0;
    #1;
    psg_regs[psg_latch] = bus_out;
  endtask

  task automatic test_reset();
    bit acc;
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (bus_out !== 8'h00) begin miscompares++; $display("FAIL rst_bus got=%h exp=00", bus_out); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got=%b exp=0", busy); end
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready got=%b exp=1", req_ready); end
    vectors++; if (wr_done !== 1'b0) begin miscompares++; $display("FAIL rst_wr_done got=%b exp=0", wr_done); end
    vectors++; if (phase !== 1'b0) begin miscompares++; $display("FAIL rst_phase got=%b exp=0", phase); end
    do_reset();
    for (int i = 0; i < 10; i++) begin
      vectors++; if (bus_out !== 8'h00) begin miscompares++; $display("FAIL idle_bus cyc=%0d got=%h exp=00", cyc, bus_out); end
      vectors++; if (phase !== 1'(i % 2)) begin miscompares++; $display("FAIL idle_phase cyc=%0d got=%b exp=%0d", cyc, phase, i % 2); end
      vectors++; if (wr_done !== 1'b0) begin miscompares++; $display("FAIL idle_wr_done cyc=%0d got=%b exp=0", cyc, wr_done); end
      tick(acc);
    end
  endtask

  task automatic test_single_write();
    bit acc;
    logic [7:0] exp_b[4];
    logic       exp_p[4];
    logic       exp_w[4];
    exp_b[0] = 8'h07; exp_b[1] = 8'h38; exp_b[2] = 8'h07; exp_b[3] = 8'h38;
    exp_p[0] = 1'b1;  exp_p[1] = 1'b0;  exp_p[2] = 1'b1;  exp_p[3] = 1'b0;
    exp_w[0] = 1'b0;  exp_w[1] = 1'b0;  exp_w[2] = 1'b1;  exp_w[3] = 1'b0;
    if (cyc % 2 == 0) tick(acc);
    req_valid = 1'b1; req_addr = 4'd7; req_data = 8'h38;
    tick(acc);
    req_valid = 1'b0;
    vectors++; if (acc !== 1'b1) begin miscompares++; $display("FAIL single_accept got=%b exp=1", acc); end
    for (int i = 0; i < 4; i++) begin
      tick(acc);
      vectors++; if (bus_out !== exp_b[i]) begin miscompares++; $display("FAIL single_bus step=%0d got=%h exp=%h", i, bus_out, exp_b[i]); end
      vectors++; if (phase !== exp_p[i]) begin miscompares++; $display("FAIL single_phase step=%0d got=%b exp=%b", i, phase, exp_p[i]); end
      vectors++; if (wr_done !== exp_w[i]) begin miscompares++; $display("FAIL single_wr_done step=%0d got=%b exp=%b", i, wr_done, exp_w[i]); end
    end
  endtask

  task automatic test_back_to_back(input int n, input logic [7:0] dbase);
    bit acc;
    int sent;
    int dones;
    int guard;
    bit dut_stalled;
    bit model_full;
    sent = 0; dones = 0; guard = 0; dut_stalled = 0; model_full = 0;
    while (guard < 30 + 4 * n) begin
      if (sent < n) begin
        req_valid = 1'b1; req_addr = 4'(sent); req_data = dbase + 8'(sent);
        if (!req_ready) dut_stalled = 1'b1;
      end else begin
        req_valid = 1'b0;
      end
      tick(acc);
      if (acc) sent++;
      guard++;
      if (occ(cyc) == CAP) model_full = 1'b1;
      if (wr_done === 1'b1) dones++;
      vectors++; if (bus_out !== exp_bus(cyc)) begin miscompares++; $display("FAIL b2b_bus cyc=%0d got=%h exp=%h", cyc, bus_out, exp_bus(cyc)); end
      vectors++; if (req_ready !== exp_ready(cyc)) begin miscompares++; $display("FAIL b2b_ready cyc=%0d got=%b exp=%b", cyc, req_ready, exp_ready(cyc)); end
      vectors++; if (wr_done !== exp_wr_done(cyc)) begin miscompares++; $display("FAIL b2b_wr_done cyc=%0d got=%b exp=%b", cyc, wr_done, exp_wr_done(cyc)); end
      vectors++; if (busy !== exp_busy(cyc)) begin miscompares++; $display("FAIL b2b_busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy(cyc)); end
      if (sent >= n && !exp_busy(cyc) && !exp_wr_done(cyc) && guard > 2 * n + 12) break;
    end
    req_valid = 1'b0;
    vectors++; if (sent !== n) begin miscompares++; $display("FAIL b2b_sent got=%0d exp=%0d", sent, n); end
    vectors++; if (dones !== n) begin miscompares++; $display("FAIL b2b_done_count got=%0d exp=%0d", dones, n); end
    if (model_full) begin
      vectors++; if (dut_stalled !== 1'b1) begin miscompares++; $display("FAIL b2b_ready_drop got=%b exp=1", dut_stalled); end
    end
  endtask

  task automatic test_idle_repeat();
    bit acc;
    logic [7:0] eb;
    req_valid = 1'b1; req_addr = 4'd13; req_data = 8'h0E;
    tick(acc);
    req_valid = 1'b0;
    vectors++; if (acc !== 1'b1) begin miscompares++; $display("FAIL idle_rep_accept got=%b exp=1", acc); end
    for (int i = 0; i < 6; i++) begin
      tick(acc);
      vectors++; if (bus_out !== exp_bus(cyc)) begin miscompares++; $display("FAIL idle_rep_lead_bus cyc=%0d got=%h exp=%h", cyc, bus_out, exp_bus(cyc)); end
    end
    for (int i = 0; i < 12; i++) begin
      tick(acc);
      eb = (cyc % 2 == 1) ? 8'h0D : 8'h0E;
      vectors++; if (bus_out !== eb) begin miscompares++; $display("FAIL idle_rep_bus cyc=%0d got=%h exp=%h", cyc, bus_out, eb); end
      vectors++; if (wr_done !== 1'b0) begin miscompares++; $display("FAIL idle_rep_wr_done cyc=%0d got=%b exp=0", cyc, wr_done); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL idle_rep_busy cyc=%0d got=%b exp=0", cyc, busy); end
    end
  endtask

  task automatic test_reset_mid();
    bit acc;
    int target;
    int guard;
    target = (CAP < 3) ? CAP : 3;
    guard = 0;
    while (occ(cyc) < target && guard < 20) begin
      req_valid = 1'b1; req_addr = 4'(guard + 1); req_data = 8'h50 + 8'(guard);
      tick(acc);
      guard++;
    end
    req_valid = 1'b0;
    vectors++; if (occ(cyc) < target) begin miscompares++; $display("FAIL mid_fill got=%0d exp=%0d", occ(cyc), target); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL mid_busy_before got=%b exp=1", busy); end
    #3 rst_n = 1'b0;
    #1;
    vectors++; if (bus_out !== 8'h00) begin miscompares++; $display("FAIL mid_rst_bus got=%h exp=00", bus_out); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mid_rst_busy got=%b exp=0", busy); end
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL mid_rst_ready got=%b exp=1", req_ready); end
    vectors++; if (wr_done !== 1'b0) begin miscompares++; $display("FAIL mid_rst_wr_done got=%b exp=0", wr_done); end
    do_reset();
    for (int i = 0; i < 20; i++) begin
      tick(acc);
      vectors++; if (bus_out !== 8'h00) begin miscompares++; $display("FAIL mid_after_bus cyc=%0d got=%h exp=00", cyc, bus_out); end
      vectors++; if (wr_done !== 1'b0) begin miscompares++; $display("FAIL mid_after_wr_done cyc=%0d got=%b exp=0", cyc, wr_done); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mid_after_busy cyc=%0d got=%b exp=0", cyc, busy); end
    end
  endtask

  task automatic test_random();
    bit acc;
    int sent;
    int guard;
    sent = 0; guard = 0;
    while (guard < 3000) begin
      if (sent < 200 && $urandom_range(3, 0) != 0) begin
        req_valid = 1'b1;
        req_addr = 4'($urandom_range(15, 0));
        req_data = 8'($urandom_range(255, 0));
      end else begin
        req_valid = 1'b0;
      end
      tick(acc);
      if (acc) sent++;
      guard++;
      vectors++; if (bus_out !== exp_bus(cyc)) begin miscompares++; $display("FAIL rnd_bus cyc=%0d got=%h exp=%h", cyc, bus_out, exp_bus(cyc)); end
      vectors++; if (phase !== 1'(cyc % 2)) begin miscompares++; $display("FAIL rnd_phase cyc=%0d got=%b exp=%0d", cyc, phase, cyc % 2); end
      vectors++; if (req_ready !== exp_ready(cyc)) begin miscompares++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, req_ready, exp_ready(cyc)); end
      vectors++; if (wr_done !== exp_wr_done(cyc)) begin miscompares++; $display("FAIL rnd_wr_done cyc=%0d got=%b exp=%b", cyc, wr_done, exp_wr_done(cyc)); end
      vectors++; if (busy !== exp_busy(cyc)) begin miscompares++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy(cyc)); end
      if (sent >= 200 && !exp_busy(cyc) && !exp_wr_done(cyc)) break;
    end
    req_valid = 1'b0;
    vectors++; if (sent !== 200) begin miscompares++; $display("FAIL rnd_sent got=%0d exp=200", sent); end
    repeat (4) tick(acc);
    for (int r = 0; r < 16; r++) begin
      vectors++; if (psg_regs[r] !== sb[r]) begin miscompares++; $display("FAIL rnd_psg_reg%0d got=%h exp=%h", r, psg_regs[r], sb[r]); end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_single_write();
    test_back_to_back(5, 8'hA0);
    test_back_to_back(12, 8'hB0);
    test_idle_repeat();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/psg_bus_writer.md
PSG_BUS_WRITER -- requirements
Module: psg_bus_writer

Interface
REQ-001 The module SHALL have parameter FIFO_DEPTH, default 4, giving the request-buffer entries (power of two, 2..16).
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock, shared with the PSG register file.
REQ-003 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have port req_valid, input, 1 bit: the write request is valid.
REQ-005 The module SHALL have port req_ready, output, 1 bit: the module accepts a request this cycle.
REQ-006 The module SHALL have port req_addr, input, 4 bits: the PSG register index, 0..15.
REQ-007 The module SHALL have port req_data, input, 8 bits: the register value.
REQ-008 The module SHALL have port bus_out, output, 8 bits, registered: drives the PSG ui_in data bus.
REQ-009 The module SHALL have port phase, output, 1 bit: mirrors the PSG latch bit (0 = data phase, 1 = address phase).
REQ-010 The module SHALL have port busy, output, 1 bit: high when the FIFO is non-empty or a transaction is in flight.
REQ-011 The module SHALL have port wr_done, output, 1 bit: one-cycle pulse when a transaction's data byte has been sampled.

Function
REQ-012 phase SHALL reset to 0 and toggle on every clk edge, matching the PSG latch, which resets to 0 in the same cycle.
REQ-013 The PSG SHALL sample bus_out at the end of each cycle: as address in phase=1 cycles and as data in phase=0 cycles; bus_out SHALL therefore be loaded one edge ahead of the sampling cycle.
REQ-014 A request SHALL be accepted on an edge where req_valid && req_ready, and pushed into the FIFO; req_ready SHALL equal !full, with no bypass when full.
REQ-015 At each edge where phase=0 (the edge entering the address phase): if the FIFO was non-empty before that edge, the module SHALL pop the head into cur_addr/cur_data and set bus_out <= {4'b0, head addr}; otherwise it SHALL set bus_out <= {4'b0, cur_addr}.
REQ-016 At each edge where phase=1 (the edge entering the data phase), the module SHALL set bus_out <= cur_data.
REQ-017 When idle, the module SHALL re-present the last address and data pair, so the PSG's unconditional per-data-phase write is idempotent.
REQ-018 wr_done SHALL be high in the cycle after the data-phase cycle of a popped transaction, and SHALL NOT pulse for idle re-presentations.
REQ-019 Minimum latency SHALL be: a request accepted at edge E drives its address in the first address-phase cycle starting strictly after E; throughput SHALL be one write per 2 cycles.
REQ-020 A simultaneous push and pop SHALL be legal and leave the occupancy unchanged; a push into an empty FIFO SHALL NOT pop on the same edge.
REQ-021 FIFO pointers SHALL wrap modulo FIFO_DEPTH; the occupancy counter SHALL be log2(FIFO_DEPTH)+1 bits wide.

Reset
REQ-022 On rst_n=0, the module SHALL asynchronously clear phase, bus_out, cur_addr, cur_data, the FIFO pointers and occupancy, and wr_done; busy=0 and req_ready=1.
REQ-023 Reset values SHALL equal the PSG reset state (register 0 = 0), so idle re-writes after reset are harmless.
REQ-024 Reset asserted mid-transaction SHALL discard all queued and in-flight requests without emitting a wr_done.

Configuration
REQ-025 With macro PSG_BUS_WRITER_FIFO_EN defined, the module SHALL use a FIFO_DEPTH-entry FIFO as specified.
REQ-026 Without PSG_BUS_WRITER_FIFO_EN, the module SHALL use a single-entry holding register (FIFO_DEPTH ignored, req_ready = !held), with identical bus timing.

Structure
REQ-027 Package psg_pkg SHALL hold PSG_ADDR_W=4, PSG_DATA_W=8, and the phase enum PH_DATA=0, PH_ADDR=1.
REQ-028 The FIFO SHALL be implemented as sub-module psg_req_fifo (parameter DEPTH; ports push, pop, din, dout, full, empty).

Verification
REQ-029 Reset, then idle for 10 cycles: bus_out SHALL read 0 in every cycle, phase SHALL alternate 0,1,0,1..., and there SHALL be no wr_done.
REQ-030 Single write addr=7, data=0x38 accepted on a phase=1 edge: the next cycle SHALL show bus_out=0x07 with phase=1, the following cycle 0x38 with phase=0, and wr_done SHALL pulse the cycle after.
REQ-031 Back-to-back 5 writes (addr 0..4, data 0xA0..0xA4) with FIFO_DEPTH=4: req_ready SHALL drop when 4 are queued, all 5 pairs SHALL appear in order at 2-cycle spacing, and 5 wr_done pulses SHALL occur.
REQ-032 After a write (addr=13, data=0x0E), idle: bus_out SHALL alternate 0x0D/0x0E indefinitely with no wr_done.
REQ-033 Assert rst_n low mid-transaction, with 3 queued: bus_out SHALL read 0 immediately, busy=0, and the queued requests SHALL never appear.
REQ-034 A PSG model in the bench SHALL match a scoreboard of all 16 registers after 200 random writes, in both configurations.
